// File: rtl/mem_stage.sv
// Memory access stage: issues one data-memory request per aligned load or
// store, stalls upstream until the memory acknowledges, and resolves the
// writeback value (ALU / loaded data / PC+4 / LO) into registered outputs.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | accept instruction inputs; non-memory ops write back directly
//   BUSY  | request outstanding, bus held, waiting for dmAck
module mem_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PCPlus4i,
  input  logic [31:0] ALUResi,
  input  logic [31:0] Wloi,
  input  logic [4:0]  regWAddri,
  input  logic [1:0]  whatToRegi,
  input  logic        regWritei,
  input  logic        memWritei,
  input  logic [31:0] memDatai,
  input  logic [1:0]  readModei,
  input  logic [1:0]  movei,
  input  logic [31:0] dmRData,
  input  logic        dmAck,
  output logic        dmReq,
  output logic        dmWe,
  output logic [31:0] dmAddr,
  output logic [31:0] dmWData,
  output logic [3:0]  dmBe,
  output logic        stallo,
  output logic        misalignedo,
  output logic [31:0] wbDatao,
  output logic [4:0]  regWAddro,
  output logic        regWriteo,
  output logic [1:0]  moveo
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] MODE_WORD  = 2'b00;
  localparam logic [1:0] MODE_HALF  = 2'b01;

  state_t r_state;
  state_t w_next_state;

  // Copies of the in-flight instruction, captured when the request issues.
  logic [1:0]  r_mode;
  logic [1:0]  r_off;
  logic        r_store;
  logic [4:0]  r_waddr;
  logic        r_wen;
  logic [1:0]  r_move;

  logic        w_is_mem;
  logic        w_is_store;
  logic        w_misaligned;
  logic        w_start;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_wb_sel;
  logic [31:0] w_ld_data;

  assign w_is_mem   = memWritei | (whatToRegi == 2'b01);
  assign w_is_store = memWritei;
  assign w_off      = ALUResi[1:0];
  assign w_misaligned = w_is_mem &
                        (((readModei == MODE_WORD) && (w_off != 2'b00)) ||
                         ((readModei == MODE_HALF) && w_off[0]));
  assign w_start    = w_is_mem & ~w_misaligned;

  // Next-state and stall: stall while a request is being launched or is outstanding.
  always_comb begin
    w_next_state = r_state;
    stallo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next_state = BUSY;
          stallo       = 1'b1;
        end
      end
      BUSY: begin
        if (dmAck) begin
          w_next_state = IDLE;
        end else begin
          stallo = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
    if (RST) begin
      stallo = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Store lane steering: big-endian, offset 0 is the most significant byte.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = memDatai;
    case (readModei)
      MODE_WORD: begin
        w_be    = 4'b1111;
        w_wdata = memDatai;
      end
      MODE_HALF: begin
        w_be    = w_off[1] ? 4'b0011 : 4'b1100;
        w_wdata = {memDatai[15:0], memDatai[15:0]};
      end
      default: begin
        case (w_off)
          2'b00:   w_be = 4'b1000;
          2'b01:   w_be = 4'b0100;
          2'b10:   w_be = 4'b0010;
          default: w_be = 4'b0001;
        endcase
        w_wdata = {4{memDatai[7:0]}};
      end
    endcase
  end

  // Load extraction from the returned word using the latched size/offset.
  always_comb begin
    logic [15:0] v_half;
    logic [7:0]  v_byte;
    v_half    = r_off[1] ? dmRData[15:0] : dmRData[31:16];
    case (r_off)
      2'b00:   v_byte = dmRData[31:24];
      2'b01:   v_byte = dmRData[23:16];
      2'b10:   v_byte = dmRData[15:8];
      default: v_byte = dmRData[7:0];
    endcase
    case (r_mode)
      MODE_WORD: w_ld_data = dmRData;
      MODE_HALF: w_ld_data = {{16{v_half[15]}}, v_half};
      2'b10:     w_ld_data = {{24{v_byte[7]}}, v_byte};
      default:   w_ld_data = {24'h0, v_byte};
    endcase
  end

  // Writeback source for instructions that complete without a memory access.
  always_comb begin
    case (whatToRegi)
      2'b00:   w_wb_sel = ALUResi;
      2'b10:   w_wb_sel = PCPlus4i;
      2'b11:   w_wb_sel = Wloi;
      default: w_wb_sel = 32'h0;
    endcase
  end

  // Bus, latched instruction and writeback registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dmReq       <= 1'b0;
      dmWe        <= 1'b0;
      dmAddr      <= 32'h0;
      dmWData     <= 32'h0;
      dmBe        <= 4'h0;
      misalignedo <= 1'b0;
      wbDatao     <= 32'h0;
      regWAddro   <= 5'h0;
      regWriteo   <= 1'b0;
      moveo       <= 2'h0;
      r_mode      <= 2'h0;
      r_off       <= 2'h0;
      r_store     <= 1'b0;
      r_waddr     <= 5'h0;
      r_wen       <= 1'b0;
      r_move      <= 2'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            dmReq       <= 1'b1;
            dmWe        <= w_is_store;
            dmAddr      <= {ALUResi[31:2], 2'b00};
            dmWData     <= w_is_store ? w_wdata : 32'h0;
            dmBe        <= w_is_store ? w_be : 4'b1111;
            r_mode      <= readModei;
            r_off       <= w_off;
            r_store     <= w_is_store;
            r_waddr     <= regWAddri;
            r_wen       <= regWritei;
            r_move      <= movei;
            misalignedo <= 1'b0;
            wbDatao     <= 32'h0;
            regWAddro   <= 5'h0;
            regWriteo   <= 1'b0;
            moveo       <= 2'h0;
          end else begin
            dmReq       <= 1'b0;
            misalignedo <= w_misaligned;
            wbDatao     <= w_wb_sel;
            regWAddro   <= regWAddri;
            regWriteo   <= regWritei & ~w_misaligned;
            moveo       <= movei;
          end
        end
        BUSY: begin
          misalignedo <= 1'b0;
          if (dmAck) begin
            dmReq     <= 1'b0;
            dmWe      <= 1'b0;
            wbDatao   <= r_store ? 32'h0 : w_ld_data;
            regWAddro <= r_waddr;
            regWriteo <= r_wen & ~r_store;
            moveo     <= r_move;
          end else begin
            wbDatao   <= 32'h0;
            regWAddro <= 5'h0;
            regWriteo <= 1'b0;
            moveo     <= 2'h0;
          end
        end
        default: begin
          dmReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PCPlus4i, ALUResi, Wloi, memDatai, dmRData;
  logic [4:0]  regWAddri;
  logic [1:0]  whatToRegi, readModei, movei;
  logic        regWritei, memWritei, dmAck;
  logic        dmReq, dmWe, stallo, misalignedo, regWriteo;
  logic [31:0] dmAddr, dmWData, wbDatao;
  logic [3:0]  dmBe;
  logic [4:0]  regWAddro;
  logic [1:0]  moveo;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mem_stage dut (
    .CLK(CLK), .RST(RST), .PCPlus4i(PCPlus4i), .ALUResi(ALUResi), .Wloi(Wloi),
    .regWAddri(regWAddri), .whatToRegi(whatToRegi), .regWritei(regWritei),
    .memWritei(memWritei), .memDatai(memDatai), .readModei(readModei),
    .movei(movei), .dmRData(dmRData), .dmAck(dmAck), .dmReq(dmReq),
    .dmWe(dmWe), .dmAddr(dmAddr), .dmWData(dmWData), .dmBe(dmBe),
    .stallo(stallo), .misalignedo(misalignedo), .wbDatao(wbDatao),
    .regWAddro(regWAddro), .regWriteo(regWriteo), .moveo(moveo)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: value delivered by a load of the given size at byte offset off.
  function automatic logic [31:0] ref_load(input logic [1:0] mode, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [31:0] v;
    int sh;
    case (mode)
      2'b00: v = rd;
      2'b01: begin
        sh = (2 - int'(off)) * 8;
        v  = (rd >> sh) & 32'h0000FFFF;
        if (v >= 32'h8000) v = v + 32'hFFFF0000;
      end
      default: begin
        sh = (3 - int'(off)) * 8;
        v  = (rd >> sh) & 32'h000000FF;
        if (mode == 2'b10 && v >= 32'h80) v = v + 32'hFFFFFF00;
      end
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_be(input logic [1:0] mode, input logic [1:0] off);
    case (mode)
      2'b00:   return 32'hF;
      2'b01:   return 32'h3 << (2 - int'(off));
      default: return 32'h1 << (3 - int'(off));
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] mode, input logic [31:0] d);
    case (mode)
      2'b00:   return d;
      2'b01:   return (d & 32'hFFFF) * 32'h00010001;
      default: return (d & 32'hFF) * 32'h01010101;
    endcase
  endfunction

  task automatic check_zero(input string tag);
    check_val({tag, "_dmReq"},  32'(dmReq), 0);
    check_val({tag, "_dmWe"},   32'(dmWe), 0);
    check_val({tag, "_dmAddr"}, dmAddr, 0);
    check_val({tag, "_dmWData"}, dmWData, 0);
    check_val({tag, "_dmBe"},   32'(dmBe), 0);
    check_val({tag, "_mis"},    32'(misalignedo), 0);
    check_val({tag, "_wb"},     wbDatao, 0);
    check_val({tag, "_waddr"},  32'(regWAddro), 0);
    check_val({tag, "_wen"},    32'(regWriteo), 0);
    check_val({tag, "_move"},   32'(moveo), 0);
  endtask

  task automatic scramble();
    PCPlus4i = $urandom; ALUResi = $urandom; Wloi = $urandom; memDatai = $urandom;
    regWAddri = 5'($urandom); whatToRegi = 2'($urandom); readModei = 2'($urandom);
    movei = 2'($urandom); regWritei = 1'($urandom); memWritei = 1'($urandom);
  endtask

  // kind: 0 ALU, 1 load, 2 PC+4, 3 LO, 4 store. d = BUSY cycles before dmAck.
  task automatic do_op(input int kind, input logic [31:0] addr, input logic [1:0] mode,
                       input logic [31:0] sdata, input logic [31:0] rdata, input int d,
                       input logic [4:0] wa, input logic wen, input logic [1:0] mv,
                       input logic [31:0] pc, input logic [31:0] lo);
    logic mem, mis, req;
    logic [31:0] exp_wb;
    int stall_cnt;
    logic [31:0] held_addr;
    mem = (kind == 1) || (kind == 4);
    mis = mem && ((mode == 2'b00 && addr[1:0] != 2'b00) || (mode == 2'b01 && addr[0]));
    req = mem && !mis;
    case (kind)
      0: exp_wb = addr;
      2: exp_wb = pc;
      3: exp_wb = lo;
      default: exp_wb = 0;
    endcase
    @(negedge CLK);
    ALUResi = addr; readModei = mode; memDatai = sdata; dmRData = rdata;
    regWAddri = wa; regWritei = wen; movei = mv; PCPlus4i = pc; Wloi = lo;
    memWritei  = (kind == 4);
    whatToRegi = (kind == 1) ? 2'b01 : (kind == 2) ? 2'b10 : (kind == 3) ? 2'b11 : 2'b00;
    dmAck = mem ? 1'b0 : 1'($urandom_range(0, 1));
    #1;
    check_val("stall_idle", 32'(stallo), 32'(req));
    stall_cnt = req ? 1 : 0;
    @(posedge CLK); #1;
    dmAck = 1'b0;
    if (!req) begin
      check_val("noreq_dmReq", 32'(dmReq), 0);
      check_val("noreq_mis",   32'(misalignedo), 32'(mis));
      check_val("noreq_wen",   32'(regWriteo), 32'(wen && !mis));
      check_val("noreq_waddr", 32'(regWAddro), 32'(wa));
      check_val("noreq_move",  32'(moveo), 32'(mv));
      if (!mis) check_val("noreq_wb", wbDatao, exp_wb);
    end else begin
      check_val("req_dmReq",  32'(dmReq), 1);
      check_val("req_dmWe",   32'(dmWe), 32'(kind == 4));
      check_val("req_dmAddr", dmAddr, addr & 32'hFFFFFFFC);
      check_val("req_dmBe",   32'(dmBe), (kind == 4) ? ref_be(mode, addr[1:0]) : 32'hF);
      if (kind == 4) check_val("req_dmWData", dmWData, ref_wdata(mode, sdata));
      check_val("req_bubble_wen", 32'(regWriteo), 0);
      check_val("req_bubble_wb",  wbDatao, 0);
      held_addr = dmAddr;
      scramble();
      for (int k = 0; k < d; k++) begin
        @(negedge CLK); #1;
        if (stallo) stall_cnt++;
        check_val("busy_dmReq",  32'(dmReq), 1);
        check_val("busy_dmAddr", dmAddr, held_addr);
      end
      @(negedge CLK);
      dmAck = 1'b1;
      #1;
      check_val("ack_stall", 32'(stallo), 0);
      @(posedge CLK); #1;
      dmAck = 1'b0;
      check_val("done_dmReq", 32'(dmReq), 0);
      check_val("done_wen",   32'(regWriteo), 32'(kind == 1 && wen));
      check_val("done_waddr", 32'(regWAddro), 32'(wa));
      check_val("done_move",  32'(moveo), 32'(mv));
      check_val("done_mis",   32'(misalignedo), 0);
      if (kind == 1) check_val("done_load", wbDatao, ref_load(mode, addr[1:0], rdata));
      check_val("stall_cycles", stall_cnt, d + 1);
    end
  endtask

  initial begin
    RST = 1'b1; dmAck = 1'b0; dmRData = 0;
    PCPlus4i = 0; ALUResi = 0; Wloi = 0; memDatai = 0; regWAddri = 0;
    whatToRegi = 0; readModei = 0; movei = 0; regWritei = 0; memWritei = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_zero("reset");
    check_val("reset_stall", 32'(stallo), 0);
    RST = 1'b0;

    do_op(0, 32'h12345678, 2'b00, 0, 0, 0, 5'd5, 1'b1, 2'b00, 32'h4, 32'h8);
    do_op(1, 32'h00000103, 2'b10, 0, 32'hAABBCC80, 3, 5'd7, 1'b1, 2'b01, 32'h4, 32'h8);
    do_op(4, 32'h00000202, 2'b01, 32'h0000BEEF, 0, 2, 5'd9, 1'b1, 2'b10, 32'h4, 32'h8);
    do_op(1, 32'h00000301, 2'b00, 0, 0, 0, 5'd3, 1'b1, 2'b11, 32'h4, 32'h8);
    do_op(1, 32'h00000000, 2'b11, 0, 32'h80FFFFFF, 1, 5'd4, 1'b1, 2'b00, 32'h4, 32'h8);
    do_op(2, 32'h0, 2'b00, 0, 0, 0, 5'd31, 1'b1, 2'b01, 32'hCAFE0004, 32'h8);
    do_op(3, 32'h0, 2'b00, 0, 0, 0, 5'd30, 1'b0, 2'b10, 32'h4, 32'hDEAD0001);

    // Reset while a request is outstanding; a late ack must be ignored.
    @(negedge CLK);
    ALUResi = 32'h40; whatToRegi = 2'b01; memWritei = 0; readModei = 0; regWritei = 1;
    @(posedge CLK); #1;
    check_val("rst_busy_dmReq", 32'(dmReq), 1);
    @(negedge CLK);
    RST = 1'b1;
    ALUResi = 0; whatToRegi = 0; regWritei = 0; movei = 0; regWAddri = 0;
    #1;
    check_val("rst_busy_stall", 32'(stallo), 0);
    @(posedge CLK); #1;
    check_zero("rst_busy");
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    dmAck = 1'b1;
    #1;
    check_val("late_ack_stall", 32'(stallo), 0);
    @(posedge CLK); #1;
    dmAck = 1'b0;
    check_val("late_ack_dmReq", 32'(dmReq), 0);
    check_val("late_ack_wen",   32'(regWriteo), 0);

    for (int i = 0; i < 300; i++) begin
      do_op(int'($urandom_range(0, 4)), $urandom, 2'($urandom), $urandom, $urandom,
            int'($urandom_range(0, 4)), 5'($urandom), 1'($urandom), 2'($urandom),
            $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter none; all widths fixed as listed.
REQ-002 SHALL have ports, clock and reset first:
 CLK  in  1  rising-edge clock, single domain
 RST  in  1  synchronous reset, active-high
 PCPlus4i  in  32  PC+4 from EX/MEM register
 ALUResi  in  32  ALU result; byte address for loads/stores
 Wloi  in  32  LO-register value
 regWAddri  in  5  destination register
 whatToRegi  in  2  writeback source: 00 ALU, 01 memory, 10 PC+4, 11 Wlo
 regWritei  in  1  register write enable
 memWritei  in  1  store request
 memDatai  in  32  store data, right-justified
 readModei  in  2  access size: 00 word, 01 half signed, 10 byte signed, 11 byte unsigned
 movei  in  2  move-class tag, passed through
 dmRData  in  32  data memory read word
 dmAck  in  1  data memory completion, one-cycle pulse
 dmReq  out  1  data memory request
 dmWe  out  1  write enable, valid with dmReq
 dmAddr  out  32  word address, bits[1:0] zero
 dmWData  out  32  lane-aligned store data
 dmBe  out  4  byte enables, bit3 = bits 31:24
 stallo  out  1  hold EX/MEM register and upstream stages
 misalignedo  out  1  registered alignment fault flag, one cycle
 wbDatao  out  32  registered resolved writeback data
 regWAddro  out  5  registered destination
 regWriteo  out  1  registered write enable
 moveo  out  2  registered move tag

Function
REQ-003 SHALL treat an input as memory op when memWritei=1 or whatToRegi=01.
REQ-004 SHALL use big-endian lanes: addr[1:0]=00 selects bits 31:24, 11 selects bits 7:0; halfword at 00 selects 31:16, at 10 selects 15:0.
REQ-005 SHALL flag misaligned: word with addr[1:0]!=00, half with addr[0]=1.
REQ-006 SHALL implement FSM states IDLE and BUSY.
REQ-007 IDLE, non-memory op: no stall; at edge WB regs load wbData per whatToRegi (ALUResi/PCPlus4i/Wloi), regWAddri, regWritei, movei.
REQ-008 IDLE, aligned memory op: stallo=1 combinationally; at edge go BUSY, register dmReq=1, dmWe, dmAddr, dmWData, dmBe; WB regs load bubble (regWriteo=0, wbDatao=0).
REQ-009 IDLE, misaligned memory op: no request, no stall; at edge misalignedo=1, regWriteo=0, other WB regs load normally.
REQ-010 BUSY: dmReq and bus outputs held constant; stallo=1 while dmAck=0.
REQ-011 BUSY with dmAck=1: stallo=0 that cycle; at edge dmReq=0, state IDLE, WB regs load instruction result (load: extracted/extended dmRData; store: regWriteo=0).
REQ-012 Load extraction: word unchanged; half sign-extended from bit 15; byte signed from bit 7; byte unsigned zero-filled.
REQ-013 Store: dmWData replicates byte to all four lanes or half to both halves; dmBe = 1111 word, 1100/0011 half, one-hot byte per REQ-004; loads drive dmBe=1111, dmWe=0.
REQ-014 dmAck in IDLE SHALL be ignored.
REQ-015 Instruction inputs SHALL be sampled only in IDLE; BUSY uses internally latched copies.
REQ-016 Back-to-back memory ops: each incurs one IDLE request cycle plus BUSY wait; no request overlap.

Reset
REQ-017 RST=1 at an edge SHALL force IDLE, dmReq=0, dmWe=0, dmAddr=0, dmWData=0, dmBe=0, misalignedo=0, wbDatao=0, regWAddro=0, regWriteo=0, moveo=0.
REQ-018 RST during BUSY SHALL abandon the access; a later dmAck SHALL be ignored; stallo=0 while RST=1.

Verification
REQ-019 ALU op whatToRegi=00, ALUResi=0x12345678, regWAddri=5, regWritei=1 -> next cycle wbDatao=0x12345678, regWAddro=5, regWriteo=1, stallo never high.
REQ-020 Load byte signed addr 0x103, dmAck 3 cycles after dmReq, dmRData=0xAABBCC80 -> dmAddr=0x100, stallo high 4 cycles, then wbDatao=0xFFFFFF80, regWriteo=1.
REQ-021 Store half addr 0x202, memDatai=0x0000BEEF -> dmWe=1, dmBe=0011, dmWData=0xBEEFBEEF, regWriteo=0 after ack.
REQ-022 Load word addr 0x301 -> no dmReq, misalignedo=1 one cycle, regWriteo=0.
REQ-023 RST asserted in BUSY, dmAck two cycles later -> dmReq=0 next edge, all outputs zero, no writeback.
REQ-024 Load half unsigned-check: byte unsigned addr 0x0, dmRData=0x80FFFFFF -> wbDatao=0x00000080.
